// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the seq_tx serial pattern transmitter.
package seq_tx_pkg;

  localparam int unsigned DEF_DATA_W = 12;

  // Pattern recognised by the optional match counter
  localparam logic [3:0] PATTERN = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S11,
    S110,
    S1101
  } det_state_t;

endpackage

// File: rtl/seq_tx_if.sv
// Load/serial-output bundle between a frame source and the seq_tx serializer.
interface seq_tx_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
);

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [LEN_W-1:0]  len;
  logic              ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  match_cnt;

  // Frame source side
  modport master (
    output load, data_in, len,
    input  ready, tx_bit, tx_valid, done, err, match_cnt
  );

  // Serializer side
  modport slave (
    input  load, data_in, len,
    output ready, tx_bit, tx_valid, done, err, match_cnt
  );

endinterface

// File: rtl/seq_tx_match.sv
// Overlapping 1101 detector with a saturating match counter.
// Present only when SEQ_TX_MATCH_COUNT_EN is defined.
`ifdef SEQ_TX_MATCH_COUNT_EN
module seq_tx_match
  import seq_tx_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [LEN_W-1:0] match_cnt
);

  det_state_t       det_q;
  det_state_t       det_nxt_c;
  logic [LEN_W-1:0] cnt_q;

  // Moore detector next state; holds while the serial bit is not qualified
  always_comb begin
    det_nxt_c = det_q;
    if (bit_valid) begin
      case (det_q)
        S0:      det_nxt_c = (bit_in == PATTERN[3]) ? S1    : S0;
        S1:      det_nxt_c = (bit_in == PATTERN[2]) ? S11   : S0;
        S11:     det_nxt_c = (bit_in == PATTERN[1]) ? S110  : S11;
        S110:    det_nxt_c = (bit_in == PATTERN[0]) ? S1101 : S0;
        S1101:   det_nxt_c = bit_in ? S11 : S0;
        default: det_nxt_c = S0;
      endcase
    end
  end

  // Count on entry to S1101 so the total is final in the cycle after the last bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      det_q <= S0;
      cnt_q <= '0;
    end else if (clr) begin
      det_q <= S0;
      cnt_q <= '0;
    end else begin
      det_q <= det_nxt_c;
      if (bit_valid && (det_nxt_c == S1101) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  assign match_cnt = cnt_q;

endmodule
`endif

// File: rtl/seq_tx.sv
// Serial pattern transmitter: loads a word plus bit count, shifts it out MSB-first.
// Optional feature macro: SEQ_TX_MATCH_COUNT_EN (adds the 1101 match counter).
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic    clk,
  input  logic    n_rst,
  seq_tx_if.slave bus
);

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [LEN_W-1:0]  rem_q;
  logic              tx_bit_q;
  logic              tx_valid_q;
  logic              done_q;
  logic              err_q;

  logic              len_ok_c;
  logic              accept_c;
  logic [LEN_W-1:0]  first_idx_c;
  logic [LEN_W-1:0]  next_idx_c;

  // Load qualification and bit indices
  assign len_ok_c    = (bus.len != '0) && (bus.len <= LEN_W'(DATA_W));
  assign accept_c    = (state_q == IDLE) && bus.load && len_ok_c;
  assign first_idx_c = bus.len - LEN_W'(1);
  assign next_idx_c  = rem_q - LEN_W'(1);

  // Frame FSM; rem_q is both the bit index on air and the bits still to send
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      rem_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            shreg_q    <= bus.data_in;
            tx_bit_q   <= bus.data_in[first_idx_c];
            tx_valid_q <= 1'b1;
            rem_q      <= first_idx_c;
            state_q    <= SHIFT;
          end else if (bus.load) begin
            err_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (rem_q != '0) begin
            tx_bit_q <= shreg_q[next_idx_c];
            rem_q    <= next_idx_c;
          end else begin
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

`ifdef SEQ_TX_MATCH_COUNT_EN
  // Detector watches the registered serial stream and restarts on each accepted load
  seq_tx_match #(
    .LEN_W (LEN_W)
  ) u_match (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (accept_c),
    .bit_in    (tx_bit_q),
    .bit_valid (tx_valid_q),
    .match_cnt (bus.match_cnt)
  );
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: a cycle-level frame model predicts every
// serial bit, done and err pulse with its cycle number; a monitor compares.
module tb_seq_tx;
  import seq_tx_pkg::*;

  localparam int unsigned DW = 12;
  localparam int unsigned LW = $clog2(DW + 1);

  logic tb_clk = 1'b0;
  logic n_rst;

  always #5 tb_clk = ~tb_clk;

  seq_tx_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  seq_tx #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // kind: 0 = serial bit, 1 = done pulse (val = match count), 2 = err pulse
  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   idle_from  = 0;
  int   hold_match = 0;
  int   checks     = 0;
  int   errors     = 0;

  // Edge counter: after edge n, cyc == n
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Overlapping occurrences of the pattern in the transmitted bits
  function automatic int ref_matches(logic [DW-1:0] d, int l);
    int n;
    logic [3:0] w;
    n = 0;
    for (int i = l - 1; i >= 3; i--) begin
      w = {d[i], d[i-1], d[i-2], d[i-3]};
      if (w == PATTERN) n++;
    end
`ifndef SEQ_TX_MATCH_COUNT_EN
    n = 0;
`endif
    if (n > (1 << LW) - 1) n = (1 << LW) - 1;
    return n;
  endfunction

  // Drive one cycle of inputs; the model decides what the next edge does
  task automatic drive(bit ld, logic [DW-1:0] d, int l);
    exp_t e;
    bus.load    = ld;
    bus.data_in = d;
    bus.len     = LW'(l);
    @(posedge tb_clk);
    #1;
    if (ld && n_rst && ((cyc - 1) >= idle_from)) begin
      if (l >= 1 && l <= DW) begin
        for (int k = 0; k < l; k++) begin
          e.cyc = cyc + k; e.kind = 0; e.val = int'(d[l-1-k]);
          q.push_back(e);
        end
        e.cyc = cyc + l; e.kind = 1; e.val = ref_matches(d, l);
        q.push_back(e);
        idle_from = cyc + l + 1;
      end else begin
        e.cyc = cyc; e.kind = 2; e.val = 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic send(logic [DW-1:0] d, int l);
    drive(1'b1, d, l);
    repeat (l + 2) drive(1'b0, '0, 0);
  endtask

  // Monitor: compares outputs against the scoreboard every cycle
  always @(negedge tb_clk) begin : monitor
    exp_t it;
    int ev, eb, ed, em, ee;
    if (!n_rst) begin
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_ready", bus.ready, 1);
      chk("rst_match_cnt", int'(bus.match_cnt), 0);
      hold_match = 0;
    end else begin
      ev = 0; eb = 0; ed = 0; em = 0; ee = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        it = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event kind=%0d due_cyc=%0d actual=absent required=present", it.kind, it.cyc);
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        it = q.pop_front();
        case (it.kind)
          0: begin ev = 1; eb = it.val; end
          1: begin ed = 1; em = it.val; end
          default: ee = 1;
        endcase
      end
      chk("tx_valid", bus.tx_valid, ev);
      chk("tx_bit", bus.tx_bit, eb);
      chk("done", bus.done, ed);
      chk("err", bus.err, ee);
      chk("ready", bus.ready, (cyc >= idle_from) ? 1 : 0);
      if (ed != 0) begin
        chk("match_cnt_done", int'(bus.match_cnt), em);
        hold_match = em;
      end
      if (cyc >= idle_from) chk("match_cnt_hold", int'(bus.match_cnt), hold_match);
`ifndef SEQ_TX_MATCH_COUNT_EN
      chk("match_cnt_off", int'(bus.match_cnt), 0);
`endif
    end
  end

  initial begin
    n_rst       = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.len     = '0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    #1;
    n_rst = 1'b1;
    idle_from = cyc;

    // Basic frames
    send(12'b0000_1101_1010, 8);
    send(12'b0011_0110_1101, 10);

    // Illegal lengths
    drive(1'b1, 12'($urandom), 0);
    drive(1'b0, '0, 0);
    drive(1'b1, 12'($urandom), 13);
    drive(1'b0, '0, 0);

    // Reset after the third bit of a 12-bit frame
    drive(1'b1, 12'($urandom), 12);
    drive(1'b0, '0, 0);
    drive(1'b0, '0, 0);
    @(negedge tb_clk);
    #1;
    n_rst = 1'b0;
    q.delete();
    idle_from = cyc;
    repeat (3) drive(1'b0, '0, 0);
    @(negedge tb_clk);
    #1;
    n_rst = 1'b1;
    idle_from = cyc;
    repeat (2) drive(1'b0, '0, 0);
    send(12'b0000_0000_1101, 4);

    // Load held high with alternating data
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i % 2 == 0) ? 12'hB6D : 12'h6DB, $urandom_range(4, 12));
    end
    repeat (14) drive(1'b0, '0, 0);

    // Shortest frame
    send(12'h001, 1);

    // Random traffic, including illegal lengths and loads during frames
    repeat (400) begin
      drive($urandom_range(0, 3) == 0, 12'($urandom), $urandom_range(0, 13));
    end
    repeat (16) drive(1'b0, '0, 0);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
